// File: rtl/rgb_pwm_gen.sv
// rgb_pwm_gen: three-channel 8-bit PWM generator for an RGB LED driver.
// A prescaler sets the PWM step rate. A 256-step phase counter forms each period.
// New settings go into a shadow register through a valid/ready handshake.
// The shadow is applied only at a period boundary, so no PWM pulse is ever cut short.
// The solid, blink, breathe and off modes shape each channel's effective duty.
module rgb_pwm_gen #(
  parameter int          PRESCALE      = 48,
  parameter int          BLINK_PERIODS = 64,
  parameter int          BREATHE_DIV   = 2,
  parameter logic [7:0]  RESET_R       = 8'd255,
  parameter logic [7:0]  RESET_G       = 8'd0,
  parameter logic [7:0]  RESET_B       = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_r,
  input  logic [7:0] cfg_g,
  input  logic [7:0] cfg_b,
  input  logic [1:0] cfg_mode,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic       period_end
);

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'b00,
    MODE_BLINK   = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_OFF     = 2'b11
  } mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    mode_e      mode;
  } cfg_t;

  localparam int PW = (PRESCALE > 1)      ? $clog2(PRESCALE)      : 1;
  localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam int DW = (BREATHE_DIV > 1)   ? $clog2(BREATHE_DIV)   : 1;

  localparam cfg_t RESET_CFG = '{r: RESET_R, g: RESET_G, b: RESET_B, mode: MODE_SOLID};

  logic [PW-1:0] presc;
  logic          step;
  logic [7:0]    phase;

  cfg_t          shadow;
  cfg_t          active;
  logic          pending;
  logic          accept;
  logic          apply;
  logic          mode_change;

  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  logic [DW-1:0] breathe_cnt;
  logic [7:0]    level;
  logic          level_up;

  logic [7:0]    eff_r;
  logic [7:0]    eff_g;
  logic [7:0]    eff_b;

  // With PRESCALE=1 the counter never leaves 0, so step is high every cycle.
  assign step        = (presc == PW'(PRESCALE - 1));
  assign period_end  = step && (phase == 8'hFF);
  assign cfg_ready   = !pending;
  assign accept      = cfg_valid && !pending;
  // accept needs pending=0 and apply needs pending=1, so the two never coincide.
  assign apply       = period_end && pending;
  assign mode_change = apply && (shadow.mode != active.mode);

  // Prescaler and phase counter: they set the PWM step rate and the period.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers update with <= so that every block samples the values from before the edge.
    if (rst) begin
      presc <= '0;
      phase <= '0;
    end else begin
      presc <= step ? '0 : presc + 1'b1;
      if (step) phase <= phase + 8'd1;
    end
  end

  // Shadow register and pending flag: the configuration handshake side.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the shadow is cleared on reset as well, so a setting that was pending before reset is dropped.
    if (rst) begin
      shadow  <= '0;
      pending <= 1'b0;
    end else if (accept) begin
      shadow  <= '{r: cfg_r, g: cfg_g, b: cfg_b, mode: mode_e'(cfg_mode)};
      pending <= 1'b1;
    end else if (apply) begin
      pending <= 1'b0;
    end
  end

  // Active configuration: it changes only at a period boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        active <= RESET_CFG;
    else if (apply) active <= shadow;
  end

  // Blink phase: the on/off phase toggles after each BLINK_PERIODS periods.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (mode_change) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (period_end && active.mode == MODE_BLINK) begin
      if (blink_cnt == BW'(BLINK_PERIODS - 1)) begin
        blink_cnt <= '0;
        blink_on  <= !blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Breathe level: a triangle wave between 0 and 255, one step per BREATHE_DIV periods.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      breathe_cnt <= '0;
      level       <= '0;
      level_up    <= 1'b1;
    end else if (mode_change) begin
      breathe_cnt <= '0;
      level       <= '0;
      level_up    <= 1'b1;
    end else if (period_end && active.mode == MODE_BREATHE) begin
      if (breathe_cnt == DW'(BREATHE_DIV - 1)) begin
        breathe_cnt <= '0;
        if (level_up) begin
          if (level == 8'hFF) begin
            level    <= 8'hFE;
            level_up <= 1'b0;
          end else begin
            level    <= level + 8'd1;
          end
        end else begin
          if (level == 8'h00) begin
            level    <= 8'h01;
            level_up <= 1'b1;
          end else begin
            level    <= level - 8'd1;
          end
        end
      end else begin
        breathe_cnt <= breathe_cnt + 1'b1;
      end
    end
  end

  // Effective duty per channel, taken from the active mode and its modulation state.
  always_comb begin
    // NOTE: giving every output a default first means no path can leave a latch behind.
    eff_r = '0;
    eff_g = '0;
    eff_b = '0;
    unique case (active.mode)
      MODE_SOLID: begin
        eff_r = active.r;
        eff_g = active.g;
        eff_b = active.b;
      end
      MODE_BLINK: begin
        if (blink_on) begin
          eff_r = active.r;
          eff_g = active.g;
          eff_b = active.b;
        end
      end
      MODE_BREATHE: begin
        eff_r = 8'(({8'd0, active.r} * {8'd0, level}) >> 8);
        eff_g = 8'(({8'd0, active.g} * {8'd0, level}) >> 8);
        eff_b = 8'(({8'd0, active.b} * {8'd0, level}) >> 8);
      end
      MODE_OFF: ;
    endcase
  end

  // PWM outputs are registered so the LED driver sees glitch-free levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_r <= 1'b0;
      pwm_g <= 1'b0;
      pwm_b <= 1'b0;
    end else begin
      pwm_r <= (phase < eff_r);
      pwm_g <= (phase < eff_g);
      pwm_b <= (phase < eff_b);
    end
  end

endmodule

// File: doc/rgb_pwm_gen.md
RGB_PWM_GEN -- requirements
Module: rgb_pwm_gen

Interface
REQ-001 SHALL have parameter PRESCALE, default 48, meaning clk cycles per PWM step (>=1).
REQ-002 SHALL have parameter BLINK_PERIODS, default 64, meaning PWM periods per blink half-phase (>=1).
REQ-003 SHALL have parameter BREATHE_DIV, default 2, meaning PWM periods per breathe level step (>=1).
REQ-004 SHALL have parameter RESET_R / RESET_G / RESET_B, defaults 255 / 0 / 0, meaning active duty after reset (red on).
REQ-005 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port cfg_valid  in  1  new configuration offered.
REQ-008 SHALL have port cfg_ready  out  1  shadow register free; transfer when cfg_valid && cfg_ready.
REQ-009 SHALL have port cfg_r / cfg_g / cfg_b  in  8 each  requested duty per channel.
REQ-010 SHALL have port cfg_mode  in  2  00 solid, 01 blink, 10 breathe, 11 off.
REQ-011 SHALL have port pwm_r / pwm_g / pwm_b  out  1 each  registered PWM; connect to RGB driver RGBxPWM inputs.
REQ-012 SHALL have port period_end  out  1  one-cycle pulse on the last clk of each PWM period.

Function
REQ-013 Prescaler SHALL count 0..PRESCALE-1 and wrap; step = prescaler==PRESCALE-1 (PRESCALE=1: step every cycle).
REQ-014 8-bit phase counter SHALL increment on step, wrapping 255->0; period = 256 steps.
REQ-015 period_end SHALL be high exactly when step && phase==255.
REQ-016 Accepted cfg SHALL load the shadow registers (duties, mode) and set pending=1; cfg_ready = !pending.
REQ-017 On period_end with pending=1, shadow SHALL copy into active registers and pending SHALL clear in the same edge.
REQ-018 Accept coinciding with period_end while pending=0: value SHALL go to shadow only; it is applied at the next period_end.
REQ-019 Active duty/mode SHALL never change except at period_end or reset (glitch-free outputs).
REQ-020 Effective duty eff_x: solid = duty_x; off = 0; blink = duty_x in on-phase, 0 in off-phase; breathe = (duty_x * level) >> 8, 16-bit product, upper 8 bits kept.
REQ-021 pwm_x SHALL register (phase < eff_x) each clk; eff=0 -> constant 0; eff=255 -> high 255 of 256 steps.
REQ-022 Blink: period counter SHALL count period_ends; after BLINK_PERIODS it clears and toggles on-phase; starts on-phase.
REQ-023 Breathe: level 8-bit, direction bit; every BREATHE_DIV period_ends level +1 when up, -1 when down; at 255 going up, direction flips to down (next step 254); at 0 going down, flips to up; no overflow/underflow.
REQ-024 When an apply (REQ-017) changes mode, blink counter, on-phase, level and direction SHALL reinitialise (counter 0, on-phase, level 0, up); same-mode apply SHALL preserve them.
REQ-025 cfg inputs SHALL be ignored when cfg_ready=0; cfg_valid may deassert without transfer.

Reset
REQ-026 While rst high: prescaler 0, phase 0, pending 0, cfg_ready 1, pwm_* 0, period_end 0, active duties RESET_R/G/B, mode solid, blink/breathe state at initial values.
REQ-027 Reset asserted mid-period or with pending=1 SHALL discard the shadow; first clk after release starts phase 0 at prescaler 0.

Verification
REQ-028 PRESCALE=1, reset release, no cfg -> pwm_r high 255 of every 256 cycles, pwm_g/pwm_b constant 0, period_end every 256 cycles.
REQ-029 Offer cfg 0/128/0 solid mid-period -> cfg_ready drops next cycle; change visible only after period_end; then pwm_g high exactly 128 of 256 cycles, pwm_r 0.
REQ-030 With pending=1, offer second cfg -> not accepted (cfg_ready 0, values unchanged); after period_end cfg_ready 1 and it is accepted.
REQ-031 Blink, BLINK_PERIODS=2, duty_b=255 -> pwm_b active 2 periods, 0 for 2 periods, repeating.
REQ-032 Breathe, BREATHE_DIV=1, duty_r=255 -> eff_r sequence 0,0,1,2.. up to 254 at level 255, then descending; no wrap to 0 from 255.
REQ-033 Assert rst during blink with pending cfg -> outputs 0 immediately; after release red solid 255, cfg_ready 1, old cfg never applied.
